// File: rtl/entrada_pkg.sv
// rtl/entrada_pkg.sv - shared types and defaults for the switch-input block
package entrada_pkg;

    typedef enum logic [1:0] {
        SOLTO        = 2'd0,
        FILTRA_PRESS = 2'd1,
        PRESSIONADO  = 2'd2,
        FILTRA_SOLTA = 2'd3
    } estado_t;

    localparam int LARGURA_PADRAO  = 16;
    localparam int DEBOUNCE_PADRAO = 500000;

endpackage

// File: rtl/filtro_botao.sv
// rtl/filtro_botao.sv - ent synchronizer and press/release debounce FSM
module filtro_botao
    import entrada_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO
) (
    input  logic clk0,
    input  logic reset,
    input  logic ent,
    output logic liberado
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CYCLES - 1);

    logic          ent_meta_q;
    logic          ent_s_q;
    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Two-flop synchronizer; idles at 1 because the button is active-low.
    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            ent_meta_q <= 1'b1;
            ent_s_q    <= 1'b1;
        end else begin
            ent_meta_q <= ent;
            ent_s_q    <= ent_meta_q;
        end
    end

    // FSM state and stability counter registers.
    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            estado_q <= SOLTO;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic; liberado fires combinationally on the edge that
    // commits a completed release, so the capture lands on that same edge.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        liberado = 1'b0;
        case (estado_q)
            SOLTO: begin
                if (!ent_s_q) begin
                    estado_d = FILTRA_PRESS;
                    cnt_d    = '0;
                end
            end
            FILTRA_PRESS: begin
                if (ent_s_q) begin
                    estado_d = SOLTO;
                end else if (cnt_q == LIMITE) begin
                    estado_d = PRESSIONADO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSIONADO: begin
                if (ent_s_q) begin
                    estado_d = FILTRA_SOLTA;
                    cnt_d    = '0;
                end
            end
            FILTRA_SOLTA: begin
                if (!ent_s_q) begin
                    estado_d = PRESSIONADO;
                end else if (cnt_q == LIMITE) begin
                    estado_d = SOLTO;
                    liberado = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

endmodule

// File: rtl/modulo_entrada_chaves.sv
// rtl/modulo_entrada_chaves.sv - debounced switch capture with valid/consume handshake
module modulo_entrada_chaves
    import entrada_pkg::*;
#(
    parameter int LARGURA         = LARGURA_PADRAO,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO
) (
    input  logic               clk0,
    input  logic               reset,
    input  logic               ent,
    input  logic [LARGURA-1:0] switch,
    input  logic               consumir,
    output logic [LARGURA-1:0] dado,
    output logic               valido,
    output logic               evento,
    output logic               perdido,
    output logic               aguardando
);

    logic [LARGURA-1:0] sw_meta_q, sw_s_q;
    logic [LARGURA-1:0] dado_q, dado_d;
    logic               valido_q, valido_d;
    logic               evento_q;
    logic               perdido_q, perdido_d;
    logic               liberado;

    filtro_botao #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filtro (
        .clk0    (clk0),
        .reset   (reset),
        .ent     (ent),
        .liberado(liberado)
    );

    // Two-flop synchronizer for the switch bank.
    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            sw_meta_q <= '0;
            sw_s_q    <= '0;
        end else begin
            sw_meta_q <= switch;
            sw_s_q    <= sw_meta_q;
        end
    end

    // Capture/handshake decision: a release either loads a new word (slot
    // free or being freed this cycle) or is dropped and flagged.
    always_comb begin
        dado_d    = dado_q;
        valido_d  = valido_q;
        perdido_d = perdido_q;
        if (liberado) begin
            if (!valido_q || consumir) begin
                dado_d    = sw_s_q;
                valido_d  = 1'b1;
                perdido_d = 1'b0;
            end else begin
                perdido_d = 1'b1;
            end
        end else if (consumir && valido_q) begin
            valido_d  = 1'b0;
            perdido_d = 1'b0;
        end
    end

    // Capture register, flags and the one-cycle attempt pulse.
    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            dado_q    <= '0;
            valido_q  <= 1'b0;
            evento_q  <= 1'b0;
            perdido_q <= 1'b0;
        end else begin
            dado_q    <= dado_d;
            valido_q  <= valido_d;
            evento_q  <= liberado;
            perdido_q <= perdido_d;
        end
    end

    assign dado       = dado_q;
    assign valido     = valido_q;
    assign evento     = evento_q;
    assign perdido    = perdido_q;
    assign aguardando = ~valido_q;

endmodule

// File: tb/tb_modulo_entrada_chaves.sv
// tb/tb_modulo_entrada_chaves.sv - scoreboard bench for modulo_entrada_chaves
module tb_modulo_entrada_chaves;

    logic        clk0 = 1'b0;
    logic        reset = 1'b0;
    logic        ent = 1'b1;
    logic [15:0] switch = 16'h0000;
    logic        consumir = 1'b0;
    logic [15:0] dado;
    logic        valido, evento, perdido, aguardando;

    typedef struct packed {
        logic [15:0] dado;
        logic        perdido;
    } exp_t;

    exp_t esperados[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    modulo_entrada_chaves #(
        .LARGURA        (16),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk0      (clk0),
        .reset     (reset),
        .ent       (ent),
        .switch    (switch),
        .consumir  (consumir),
        .dado      (dado),
        .valido    (valido),
        .evento    (evento),
        .perdido   (perdido),
        .aguardando(aguardando)
    );

    always #5 clk0 = ~clk0;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] req);
        checks++;
        if (atual !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nome, atual, req);
        end
    endtask

    task automatic ciclos(input int n);
        repeat (n) @(negedge clk0);
    endtask

    task automatic pulso_consumir();
        consumir = 1'b1;
        @(negedge clk0);
        consumir = 1'b0;
    endtask

    // Full press/release; expected result queued just before the release.
    task automatic aperta(input logic [15:0] sw, input logic [15:0] exp_dado, input logic exp_perd);
        switch = sw;
        ent = 1'b0;
        ciclos(10);
        esperados.push_back('{dado: exp_dado, perdido: exp_perd});
        ent = 1'b1;
        ciclos(10);
    endtask

    // Monitor: every evento pulse must match the oldest queued expectation.
    always @(negedge clk0) begin
        if (reset && evento === 1'b1) begin
            if (esperados.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL evento_inesperado: got evento=1 expected no capture");
            end else begin
                mon_e = esperados.pop_front();
                chk("cap_dado", {16'h0, dado}, {16'h0, mon_e.dado});
                chk("cap_valido", {31'h0, valido}, 32'h1);
                chk("cap_perdido", {31'h0, perdido}, {31'h0, mon_e.perdido});
            end
        end
    end

    initial begin
        ciclos(3);
        chk("rst_dado", {16'h0, dado}, 32'h0);
        chk("rst_valido", {31'h0, valido}, 32'h0);
        chk("rst_evento", {31'h0, evento}, 32'h0);
        chk("rst_perdido", {31'h0, perdido}, 32'h0);
        chk("rst_aguardando", {31'h0, aguardando}, 32'h1);
        reset = 1'b1;
        ciclos(3);

        // Basic capture with exact S+3 latency from the release edge.
        switch = 16'hA5C3;
        ent = 1'b0;
        ciclos(10);
        esperados.push_back('{dado: 16'hA5C3, perdido: 1'b0});
        ent = 1'b1;
        ciclos(6);
        chk("lat_antes_valido", {31'h0, valido}, 32'h0);
        ciclos(1);
        chk("lat_valido", {31'h0, valido}, 32'h1);
        chk("lat_dado", {16'h0, dado}, 32'h0000A5C3);
        chk("lat_aguardando", {31'h0, aguardando}, 32'h0);
        ciclos(10);

        // Reset while the release is still being filtered.
        switch = 16'h1111;
        ent = 1'b0;
        ciclos(10);
        ent = 1'b1;
        ciclos(4);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_dado", {16'h0, dado}, 32'h0);
        chk("mid_rst_valido", {31'h0, valido}, 32'h0);
        chk("mid_rst_perdido", {31'h0, perdido}, 32'h0);
        chk("mid_rst_aguardando", {31'h0, aguardando}, 32'h1);
        ciclos(2);
        reset = 1'b1;
        ciclos(20);
        chk("pos_rst_valido", {31'h0, valido}, 32'h0);

        // Short low glitch, then a long press with a short high glitch.
        switch = 16'h0F0F;
        ent = 1'b0;
        ciclos(2);
        ent = 1'b1;
        ciclos(10);
        chk("glitch_baixo_valido", {31'h0, valido}, 32'h0);
        ent = 1'b0;
        ciclos(20);
        ent = 1'b1;
        ciclos(2);
        ent = 1'b0;
        ciclos(20);
        chk("glitch_alto_valido", {31'h0, valido}, 32'h0);
        esperados.push_back('{dado: 16'h0F0F, perdido: 1'b0});
        ent = 1'b1;
        ciclos(10);
        chk("pos_glitch_dado", {16'h0, dado}, 32'h00000F0F);
        pulso_consumir();
        chk("pos_glitch_consumo", {31'h0, valido}, 32'h0);

        // Overrun: second word dropped, then consume clears both flags.
        aperta(16'h0001, 16'h0001, 1'b0);
        aperta(16'h0002, 16'h0001, 1'b1);
        chk("perdido_dado", {16'h0, dado}, 32'h00000001);
        chk("perdido_flag", {31'h0, perdido}, 32'h1);
        pulso_consumir();
        chk("consumo_valido", {31'h0, valido}, 32'h0);
        chk("consumo_perdido", {31'h0, perdido}, 32'h0);

        // Capture coinciding with consumir while a dropped flag is set.
        aperta(16'h1234, 16'h1234, 1'b0);
        aperta(16'h4321, 16'h1234, 1'b1);
        switch = 16'hFFFF;
        ent = 1'b0;
        ciclos(10);
        esperados.push_back('{dado: 16'hFFFF, perdido: 1'b0});
        ent = 1'b1;
        ciclos(6);
        consumir = 1'b1;
        @(negedge clk0);
        consumir = 1'b0;
        chk("simult_dado", {16'h0, dado}, 32'h0000FFFF);
        chk("simult_valido", {31'h0, valido}, 32'h1);
        chk("simult_perdido", {31'h0, perdido}, 32'h0);
        ciclos(5);
        pulso_consumir();
        chk("simult_consumo", {31'h0, valido}, 32'h0);

        // consumir with nothing pending is ignored; held button never captures.
        pulso_consumir();
        chk("ocioso_dado", {16'h0, dado}, 32'h0000FFFF);
        chk("ocioso_valido", {31'h0, valido}, 32'h0);
        chk("ocioso_perdido", {31'h0, perdido}, 32'h0);
        chk("ocioso_aguardando", {31'h0, aguardando}, 32'h1);
        switch = 16'h5A5A;
        ent = 1'b0;
        ciclos(100);
        chk("segurado_valido", {31'h0, valido}, 32'h0);
        esperados.push_back('{dado: 16'h5A5A, perdido: 1'b0});
        ent = 1'b1;
        ciclos(10);
        chk("final_dado", {16'h0, dado}, 32'h00005A5A);

        chk("pendentes", esperados.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
